// File: rtl/id_regfile_mp_pkg.sv
// Shared definitions for the ID-stage register file: clear-engine states and
// the hard-wired zero register index.
package id_regfile_mp_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } regfile_state_t;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/id_regfile_mp_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, with flush > reserve
// > write-back priority and a per-read-port lookup that hides bypassed writes.
module regfile_scoreboard
  import id_regfile_mp_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH      = 32,
  parameter int NUM_RD_PORTS       = 2
) (
  input  logic                                       Clk,
  input  logic                                       Reset_n,
  input  logic                                       run_i,
  input  logic                                       rsv_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0]              rsv_addr_i,
  input  logic                                       wr_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0]              wr_addr_i,
  input  logic                                       flush_i,
  input  logic [NUM_RD_PORTS*REGFILE_ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD_PORTS-1:0]                    rs_busy_o
);

  localparam int AW = REGFILE_ADDR_WIDTH;

  logic [REGFILE_DEPTH-1:0] busy_q, busy_d;

  // Index 0 is skipped, so x0 can never become busy and out-of-range
  // addresses never match any entry.
  always_comb begin
    busy_d = busy_q;
    if (run_i) begin
      for (int i = 1; i < REGFILE_DEPTH; i++) begin
        if (flush_i)                                 busy_d[i] = 1'b0;
        else if (rsv_en_i && int'(rsv_addr_i) == i)  busy_d[i] = 1'b1;
        else if (wr_en_i && int'(wr_addr_i) == i)    busy_d[i] = 1'b0;
      end
    end
    busy_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [AW-1:0] addr;
    logic          in_rng;
    assign addr         = rs_addr_i[p*AW +: AW];
    assign in_rng       = (int'(addr) < REGFILE_DEPTH);
    assign rs_busy_o[p] = run_i && in_rng && busy_q[addr] && !(wr_en_i && wr_addr_i == addr);
  end

endmodule

// File: rtl/id_regfile_mp.sv
// Multi-read-port integer register file with write-back bypass, busy-bit
// scoreboard and a post-reset sequential clear (one entry per cycle).
module id_regfile_mp
  import id_regfile_mp_pkg::*;
#(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH      = 32,
  parameter int NUM_RD_PORTS       = 2
) (
  input  logic                                       Clk,
  input  logic                                       Reset_n,
  input  logic [NUM_RD_PORTS*REGFILE_ADDR_WIDTH-1:0] Rs_addr,
  output logic [NUM_RD_PORTS*REG_DATA_WIDTH-1:0]     Rs_data,
  output logic [NUM_RD_PORTS-1:0]                    Rs_busy,
  input  logic [REGFILE_ADDR_WIDTH-1:0]              Rd_addr,
  input  logic [REG_DATA_WIDTH-1:0]                  Rd_wr_data,
  input  logic                                       Rd_wr_en,
  input  logic                                       Rsv_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0]              Rsv_addr,
  input  logic                                       Flush,
  output logic                                       Ready
);

  localparam int AW = REGFILE_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;

  regfile_state_t state_q, state_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic           ready_q, ready_d;
  logic [DW-1:0]  mem_q [REGFILE_DEPTH];
  logic           run;
  logic           wr_hit;

  assign run    = (state_q == RF_RUN);
  assign wr_hit = run && Rd_wr_en && (Rd_addr != AW'(REG_X0)) && (int'(Rd_addr) < REGFILE_DEPTH);
  assign Ready  = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(REGFILE_DEPTH - 1)) begin
          state_d   = RF_RUN;
          ready_d   = 1'b1;
          clr_cnt_d = '0;
        end
      end
      RF_RUN: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // No reset on the array so it can map to distributed RAM; the clear engine
  // zeroes it instead.
  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      if (!run)        mem_q[clr_cnt_q] <= '0;
      else if (wr_hit) mem_q[Rd_addr]   <= Rd_wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          in_rng;
    assign addr   = Rs_addr[p*AW +: AW];
    assign in_rng = (int'(addr) < REGFILE_DEPTH);
    assign Rs_data[p*DW +: DW] =
      (!run || !in_rng || addr == AW'(REG_X0)) ? '0 :
      (wr_hit && Rd_addr == addr)              ? Rd_wr_data :
                                                 mem_q[addr];
  end

  regfile_scoreboard #(
    .REGFILE_ADDR_WIDTH (REGFILE_ADDR_WIDTH),
    .REGFILE_DEPTH      (REGFILE_DEPTH),
    .NUM_RD_PORTS       (NUM_RD_PORTS)
  ) u_scoreboard (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .run_i      (run),
    .rsv_en_i   (Rsv_en),
    .rsv_addr_i (Rsv_addr),
    .wr_en_i    (Rd_wr_en),
    .wr_addr_i  (Rd_addr),
    .flush_i    (Flush),
    .rs_addr_i  (Rs_addr),
    .rs_busy_o  (Rs_busy)
  );

endmodule
